k2_loadable_exec: RTL and testbench

Run-control and program-store block for the K2 processor, generalising the fixed-ROM program pairing into a parametrised, loadable instruction memory. Programs are written over a valid/ready load port, then executed under run / single-step / halt / breakpoint control. It sits between the top level and a K2 core that exposes a program-counter output, an instruction input and a clock-enable.

---
 rtl/k2_exec_pkg.sv | 4 +
 rtl/k2_prog_ram.sv | 17 +
 rtl/k2_loadable_exec.sv | 65 ++++++
 tb/tb_k2_loadable_exec.sv | 123 ++++++++++++
 4 files changed

// File: rtl/k2_exec_pkg.sv
// k2_exec_pkg: run-control state encoding shared by the K2 program store and its bench
package k2_exec_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2, HALT = 2'd3} exec_state_t;
endpackage

// File: rtl/k2_prog_ram.sv
// k2_prog_ram: program store with one synchronous write port and one asynchronous read port
module k2_prog_ram #(
  parameter int INST_W = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);
  logic [INST_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/k2_loadable_exec.sv
// k2_loadable_exec: loadable program store with run/step/halt/breakpoint control for a K2 core
module k2_loadable_exec
  import k2_exec_pkg::*;
#(
  parameter int INST_W = 10,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [INST_W-1:0] ld_data,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_halt,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] core_pc,
  output logic [INST_W-1:0] core_inst,
  output logic              core_rst,
  output logic              core_en,
  output exec_state_t       state,
  output logic              loaded,
  output logic [CNT_W-1:0]  cycles
);
  exec_state_t next;
  logic skip, bp_hit, wr;
  k2_prog_ram #(.INST_W(INST_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk), .we(wr), .waddr(ld_addr), .wdata(ld_data), .raddr(core_pc), .rdata(core_inst)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = !loaded ? IDLE : cmd_step ? STEP : cmd_run ? RUN : IDLE;
      RUN:  next = (cmd_halt || bp_hit) ? HALT : RUN;
      STEP: next = HALT;
      HALT: next = cmd_halt ? IDLE : cmd_step ? STEP : cmd_run ? RUN : HALT;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    bp_hit   = bp_en && core_pc == bp_addr && !skip;
    ld_ready = state == IDLE || state == HALT;
    core_rst = state == IDLE;
    core_en  = (state == RUN && !bp_hit) || state == STEP;
    wr       = ld_valid && ld_ready;
  end
  // skip lets a resume from HALT execute the instruction sitting on the breakpoint
  always_ff @(posedge clk)
    if (rst) begin
      skip   <= 1'b0;
      loaded <= 1'b0;
      cycles <= '0;
    end else begin
      skip   <= state == HALT && next == RUN;
      loaded <= loaded || wr;
      if (state == IDLE && next != IDLE) cycles <= '0;
      else if (core_en && cycles != '1) cycles <= cycles + CNT_W'(1);
    end
endmodule

// File: tb/tb_k2_loadable_exec.sv
// tb_k2_loadable_exec: directed self-checking bench driving a simple incrementing-pc core model
module tb_k2_loadable_exec;
  import k2_exec_pkg::*;
  localparam int INST_W = 10, ADDR_W = 4, CNT_W = 4;
  logic clk = 0, rst = 1, ld_valid = 0, cmd_run = 0, cmd_step = 0, cmd_halt = 0, bp_en = 0;
  logic ld_ready, core_rst, core_en, loaded;
  logic [ADDR_W-1:0] ld_addr = '0, bp_addr = '0, core_pc = '0;
  logic [INST_W-1:0] ld_data = '0, core_inst;
  logic [CNT_W-1:0] cycles;
  exec_state_t state;
  int n = 0, errs = 0;
  k2_loadable_exec #(.INST_W(INST_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
    .bp_en(bp_en), .bp_addr(bp_addr), .core_pc(core_pc), .core_inst(core_inst),
    .core_rst(core_rst), .core_en(core_en), .state(state), .loaded(loaded), .cycles(cycles)
  );
  always #5 clk = ~clk;
  always @(posedge clk) core_pc <= core_rst ? '0 : core_en ? core_pc + 1'b1 : core_pc;
  task automatic step(int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    step(2);
    rst = 0;
    chk("rst_state", 32'(state), 0);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_cycles", 32'(cycles), 0);
    chk("rst_core_rst", 32'(core_rst), 1);
    chk("rst_ld_ready", 32'(ld_ready), 1);
    chk("rst_core_en", 32'(core_en), 0);
    cmd_run = 1; step; cmd_run = 0;
    chk("run_unloaded_state", 32'(state), 0);
    chk("run_unloaded_core_rst", 32'(core_rst), 1);
    ld_valid = 1;
    ld_addr = 4'h0; ld_data = 10'h001; step;
    ld_addr = 4'h1; ld_data = 10'h002; step;
    ld_addr = 4'h2; ld_data = 10'h003; step;
    ld_addr = 4'h3; ld_data = 10'h004; step;
    ld_addr = 4'h8; ld_data = 10'h0AA; step;
    ld_valid = 0;
    chk("loaded_set", 32'(loaded), 1);
    cmd_run = 1; step; cmd_run = 0;
    chk("run_state", 32'(state), 1);
    chk("run_core_rst", 32'(core_rst), 0);
    chk("run_core_en", 32'(core_en), 1);
    chk("run_inst_pc0", 32'(core_inst), 10'h001);
    step; chk("run_inst_pc1", 32'(core_inst), 10'h002);
    step; chk("run_inst_pc2", 32'(core_inst), 10'h003);
    step; chk("run_inst_pc3", 32'(core_inst), 10'h004);
    step(2);
    chk("run_cycles5", 32'(cycles), 5);
    ld_valid = 1; ld_addr = 4'h8; ld_data = 10'h155; #1;
    chk("run_ld_ready", 32'(ld_ready), 0);
    step; ld_valid = 0;
    step(2);
    chk("run_pc8", 32'(core_pc), 8);
    chk("run_no_write", 32'(core_inst), 10'h0AA);
    cmd_halt = 1; step; cmd_halt = 0;
    chk("halt_state", 32'(state), 3);
    chk("halt_extra_inst", 32'(cycles), 9);
    chk("halt_core_en", 32'(core_en), 0);
    chk("halt_core_rst", 32'(core_rst), 0);
    cmd_halt = 1; step; cmd_halt = 0;
    chk("abort_state", 32'(state), 0);
    chk("abort_core_rst", 32'(core_rst), 1);
    step;
    bp_en = 1; bp_addr = 4'h3;
    cmd_run = 1; step; cmd_run = 0;
    chk("bp_run_cycles", 32'(cycles), 0);
    step(3);
    chk("bp_pc", 32'(core_pc), 3);
    chk("bp_core_en", 32'(core_en), 0);
    step;
    chk("bp_halt_state", 32'(state), 3);
    chk("bp_halt_cycles", 32'(cycles), 3);
    chk("bp_halt_inst", 32'(core_inst), 10'h004);
    cmd_run = 1; step; cmd_run = 0;
    chk("resume_core_en", 32'(core_en), 1);
    step;
    chk("resume_state", 32'(state), 1);
    chk("resume_pc", 32'(core_pc), 4);
    chk("resume_cycles", 32'(cycles), 4);
    cmd_halt = 1; step; cmd_halt = 0;
    chk("halt2_cycles", 32'(cycles), 5);
    cmd_step = 1; step; cmd_step = 0;
    chk("step_state", 32'(state), 2);
    chk("step_core_en", 32'(core_en), 1);
    step;
    chk("step_back_halt", 32'(state), 3);
    chk("step_cycles", 32'(cycles), 6);
    chk("step_core_en_off", 32'(core_en), 0);
    ld_valid = 1; ld_addr = core_pc; ld_data = 10'h3FF; #1;
    chk("halt_ld_ready", 32'(ld_ready), 1);
    step; ld_valid = 0;
    chk("halt_write_inst", 32'(core_inst), 10'h3FF);
    chk("halt_write_core_rst", 32'(core_rst), 0);
    cmd_halt = 1; cmd_step = 1; step; cmd_halt = 0; cmd_step = 0;
    chk("halt_step_prio", 32'(state), 0);
    bp_en = 0; step;
    cmd_run = 1; step; cmd_run = 0;
    step(20);
    chk("sat_cycles", 32'(cycles), 4'hF);
    chk("sat_state", 32'(state), 1);
    rst = 1; step; rst = 0;
    chk("rrst_state", 32'(state), 0);
    chk("rrst_loaded", 32'(loaded), 0);
    chk("rrst_cycles", 32'(cycles), 0);
    chk("rrst_core_rst", 32'(core_rst), 1);
    step;
    chk("mem_survives", 32'(core_inst), 10'h001);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
